// File: rtl/aes_inverse_cipher_engine.sv
// ---------------------------------------------------------------------------
// AesInverseCipherEngine
//
// Iterative AES-128 decryptor. It holds one block at a time and performs one
// inverse round per clock. The caller supplies the ciphertext and the *last*
// round key. The engine walks the key schedule backwards on the fly, so no
// round-key storage is needed.
//
// Ports
//   clock      : single clock, all state changes on the rising edge
//   reset      : synchronous, active-low
//   in_valid   : ciphertext/key pair offered
//   in_ready   : engine can accept a pair this cycle (IDLE only)
//   in_data    : 128-bit ciphertext, byte 0 in bits [127:120], column-major
//   in_key     : 128-bit final round key, word 0 in bits [127:96]
//   out_valid  : plaintext available (held until out_ready)
//   out_ready  : consumer accepts the plaintext this cycle
//   out_data   : 128-bit recovered plaintext
// ---------------------------------------------------------------------------
`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif

module aes_inverse_cipher_engine #(
  parameter int NUM_ROUNDS = `NUM_ROUNDS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int CW = $clog2(NUM_ROUNDS + 1);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsmState_e;

  fsmState_e     r_fsm;
  fsmState_e     w_nextFsm;
  logic [127:0]  r_block;
  logic [127:0]  r_roundKey;
  logic [127:0]  r_outData;
  logic [CW-1:0] r_round;

  logic [7:0]    w_rcon;
  logic [127:0]  w_nextKey;
  logic [127:0]  w_keyed;
  logic [127:0]  w_mixed;

  // ---- GF(2^8) helpers ----------------------------------------------------

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (square-and-multiply); maps 0 to 0,
  // which is exactly what the S-box definition wants.
  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] acc;
    logic [7:0] pw;
    acc = 8'h01;
    pw  = x;
    for (int i = 1; i < 8; i++) begin
      pw  = gfMul(pw, pw);
      acc = gfMul(acc, pw);
    end
    return acc;
  endfunction

  // Forward S-box is needed by the key schedule, inverse S-box by the state.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gfInv(x);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] x);
    return gfInv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  // ---- Block-level transforms (byte i = row i%4, column i/4) -------------

  function automatic logic [127:0] invShiftRows(input logic [127:0] v);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = v[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] invSubBytes(input logic [127:0] v);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = invSbox(v[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] v);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = v[127-32*c -: 8];
      a1 = v[119-32*c -: 8];
      a2 = v[111-32*c -: 8];
      a3 = v[103-32*c -: 8];
      o[127-32*c -: 8] = gfMul(a0,8'h0e) ^ gfMul(a1,8'h0b) ^ gfMul(a2,8'h0d) ^ gfMul(a3,8'h09);
      o[119-32*c -: 8] = gfMul(a0,8'h09) ^ gfMul(a1,8'h0e) ^ gfMul(a2,8'h0b) ^ gfMul(a3,8'h0d);
      o[111-32*c -: 8] = gfMul(a0,8'h0d) ^ gfMul(a1,8'h09) ^ gfMul(a2,8'h0e) ^ gfMul(a3,8'h0b);
      o[103-32*c -: 8] = gfMul(a0,8'h0b) ^ gfMul(a1,8'h0d) ^ gfMul(a2,8'h09) ^ gfMul(a3,8'h0e);
    end
    return o;
  endfunction

  // One step backwards through the key schedule: k[r] from k[r+1].
  function automatic logic [127:0] invKeyStep(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, sub;
    w3  = k[31:0]   ^ k[63:32];
    w2  = k[63:32]  ^ k[95:64];
    w1  = k[95:64]  ^ k[127:96];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    w0  = k[127:96] ^ sub ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  // Rcon[idx] = x^(idx-1) in GF(2^8); unrolled doubling keeps it a pure lookup.
  function automatic logic [7:0] rconOf(input int idx);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 2; i <= NUM_ROUNDS; i++)
      if (i <= idx) rc = xtime(rc);
    return rc;
  endfunction

  // ---- Shared round datapath ----------------------------------------------

  // The register r_roundKey holds k[r+1] while round r is processed. The
  // counter value r therefore selects Rcon[r+1] for the backwards step. In
  // FINAL the counter has reached 0, which gives Rcon[1] and k[0].
  assign w_rcon    = rconOf(int'(r_round) + 1);
  assign w_nextKey = invKeyStep(r_roundKey, w_rcon);
  assign w_keyed   = invSubBytes(invShiftRows(r_block)) ^ w_nextKey;
  assign w_mixed   = invMixColumns(w_keyed);
  assign out_data  = r_outData;

  // State register plus the datapath registers. Each FSM state decides which
  // registers advance. Reset clears everything, so an aborted block leaves no
  // trace and out_data reads zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fsm      <= IDLE;
      r_block    <= '0;
      r_roundKey <= '0;
      r_round    <= '0;
      r_outData  <= '0;
    end else begin
      r_fsm <= w_nextFsm;
      case (r_fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_block    <= in_data ^ in_key;
            r_roundKey <= in_key;
            r_round    <= CW'(NUM_ROUNDS - 1);
          end
        end
        ROUND: begin
          r_block    <= w_mixed;
          r_roundKey <= w_nextKey;
          r_round    <= r_round - CW'(1);
        end
        FINAL: begin
          r_outData <= w_keyed;
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and handshake outputs. in_ready also depends on reset, so
  // nothing is offered as accepted while the engine is held in reset. The
  // output stays valid in DONE until the consumer takes it.
  always_comb begin
    w_nextFsm = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_fsm)
      IDLE: begin
        in_ready = reset;
        if (in_valid && reset) w_nextFsm = ROUND;
      end
      ROUND: begin
        if (r_round == CW'(1)) w_nextFsm = FINAL;
      end
      FINAL: begin
        w_nextFsm = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_nextFsm = IDLE;
      end
      default: begin
        w_nextFsm = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_inverse_cipher_engine.sv
// ---------------------------------------------------------------------------
// tb_aes_inverse_cipher_engine
//
// Scoreboard bench for the inverse cipher engine. The stimulus side drives
// ciphertext/key pairs. At each accept it pushes the expected plaintext and
// the accept edge number. A monitor pops these whenever out_valid rises.
// Random pairs are made by encrypting a random plaintext with a forward
// AES-128 model. That model has a table S-box and a full key expansion, and
// the last round key of the expansion is the pair's key.
// ---------------------------------------------------------------------------
module tb_aes_inverse_cipher_engine;

  localparam int NUM_ROUNDS = 10;

  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int total = 0;
  int bad = 0;
  int edgeCnt = 0;
  int lastAccept = 0;

  logic [127:0] expQ[$];
  int           acceptQ[$];

  logic [7:0]   sbox[256];
  logic [127:0] rkeys[NUM_ROUNDS+1];

  logic         prevValid = 1'b0;
  logic [127:0] heldData = '0;
  logic [127:0] monExp;
  int           monAcc;

  aes_inverse_cipher_engine #(.NUM_ROUNDS(NUM_ROUNDS)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Free-running clock with a 10-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Rising-edge counter used to measure latency and accept spacing.
  always @(posedge clock) edgeCnt <= edgeCnt + 1;

  // ---- Reference model ---------------------------------------------------

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table from the generator-3 walk over GF(2^8)*: p steps through
  // the powers of 3, and q steps through their inverses (powers of 3^-1).
  function automatic void buildSbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endfunction

  function automatic void buildKeys(input logic [127:0] k0);
    logic [31:0] w[4*(NUM_ROUNDS+1)];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
    for (int i = 4; i < 4*(NUM_ROUNDS+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NUM_ROUNDS; r++)
      rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [127:0] k;
    logic [127:0] o;
    k = rkeys[0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rnd = 1; rnd <= NUM_ROUNDS; rnd++) begin
      for (int i = 0; i < 16; i++)
        t[i] = sbox[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      if (rnd != NUM_ROUNDS) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      k = rkeys[rnd];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] randomBlock();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---- Checking ----------------------------------------------------------

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Monitor: when out_valid rises, pop the oldest expected block and its
  // accept edge. While out_valid stays high, the data must not move.
  always @(negedge clock) begin
    if (out_valid && !prevValid) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_out_valid actual=%h required=none", out_data);
      end else begin
        monExp = expQ.pop_front();
        monAcc = acceptQ.pop_front();
        checkOutput("plaintext", out_data, monExp);
        checkOutput("latency", 128'(edgeCnt - monAcc), 128'(NUM_ROUNDS));
      end
      heldData = out_data;
    end else if (out_valid && prevValid) begin
      checkOutput("hold_data", out_data, heldData);
    end
    prevValid = out_valid;
  end

  // ---- Stimulus ----------------------------------------------------------

  // Offer one pair and hold it until in_ready. The expectation is queued for
  // the edge that accepts it. The task returns just after that edge.
  task automatic applyStimulus(input logic [127:0] d, input logic [127:0] k,
                               input logic [127:0] e);
    int budget;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = d;
    in_key   = k;
    budget   = 0;
    while (!in_ready && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      in_valid = 1'b0;
      return;
    end
    expQ.push_back(e);
    acceptQ.push_back(edgeCnt + 1);
    lastAccept = edgeCnt + 1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_data  = randomBlock();
    in_key   = randomBlock();
  endtask

  // Wait until every queued result has been handed over. Optionally the
  // consumer stalls at random while waiting.
  task automatic waitDrain(input logic randomReady);
    int budget;
    budget = 0;
    while ((expQ.size() != 0 || out_valid) && budget < 300) begin
      @(negedge clock);
      out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      budget++;
    end
    if (budget >= 300) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout actual=%0d_pending required=0_pending", expQ.size());
    end
    out_ready = 1'b1;
  endtask

  // Whole-run bound in case the DUT or a wait goes astray.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios first, then random pairs with random backpressure.
  initial begin
    logic [127:0] key0;
    logic [127:0] pt;
    int           a1;
    int           n;
    logic         sawValid;

    buildSbox();
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    in_key    = '0;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset_in_ready", 128'(in_ready), 128'(0));
    checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_out_data", out_data, '0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("ready_after_reset", 128'(in_ready), 128'(1));

    // Known-answer vector
    applyStimulus(C1_CT, C1_KEY, C1_PT);
    waitDrain(1'b0);

    // Backpressure: five stalled edges, then the handshake
    out_ready = 1'b0;
    applyStimulus(B_CT, B_KEY, B_PT);
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clock);
      n++;
    end
    checkOutput("bp_valid_seen", 128'(out_valid), 128'(1));
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
      checkOutput("bp_valid_held", 128'(out_valid), 128'(1));
      @(negedge clock);
    end
    out_ready = 1'b1;
    @(negedge clock);
    checkOutput("bp_valid_dropped", 128'(out_valid), 128'(0));
    checkOutput("bp_ready_after", 128'(in_ready), 128'(1));

    // Busy input: junk pairs while rounds run, then a real second pair
    applyStimulus(C1_CT, C1_KEY, C1_PT);
    a1 = lastAccept;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = randomBlock();
      in_key   = randomBlock();
      #1;
      checkOutput("busy_in_ready", 128'(in_ready), 128'(0));
    end
    key0 = randomBlock();
    pt   = randomBlock();
    buildKeys(key0);
    applyStimulus(encrypt(pt), rkeys[NUM_ROUNDS], pt);
    checkOutput("busy_accept_spacing", 128'(lastAccept - a1), 128'(NUM_ROUNDS + 2));
    waitDrain(1'b0);

    // Reset while the round counter sits at 5
    applyStimulus(C1_CT, C1_KEY, C1_PT);
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    expQ.delete();
    acceptQ.delete();
    #1;
    checkOutput("abort_out_data", out_data, '0);
    checkOutput("abort_in_ready", 128'(in_ready), 128'(1));
    sawValid = 1'b0;
    repeat (15) begin
      @(negedge clock);
      sawValid = sawValid | out_valid;
    end
    checkOutput("abort_no_valid", 128'(sawValid), 128'(0));
    applyStimulus(B_CT, B_KEY, B_PT);
    waitDrain(1'b0);

    // Back-to-back with the consumer always ready
    out_ready = 1'b1;
    applyStimulus(C1_CT, C1_KEY, C1_PT);
    a1 = lastAccept;
    applyStimulus(B_CT, B_KEY, B_PT);
    checkOutput("b2b_accept_spacing", 128'(lastAccept - a1), 128'(NUM_ROUNDS + 2));
    waitDrain(1'b0);

    // Random pairs with random consumer stalls
    for (int i = 0; i < 10; i++) begin
      key0 = randomBlock();
      pt   = randomBlock();
      buildKeys(key0);
      applyStimulus(encrypt(pt), rkeys[NUM_ROUNDS], pt);
      waitDrain(1'b1);
    end

    repeat (3) @(negedge clock);
    checkOutput("queue_empty", 128'(expQ.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_inverse_cipher_engine.md
AES_INVERSE_CIPHER_ENGINE -- requirements
Module: aes_inverse_cipher_engine

Interface
REQ-001 SHALL have parameter: NUM_ROUNDS, default `NUM_ROUNDS (10), total AES-128 round count.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset; asserted when 0.
REQ-004 SHALL have port: in_valid  input  1  ciphertext/key pair offered.
REQ-005 SHALL have port: in_ready  output  1  engine can accept a pair this cycle.
REQ-006 SHALL have port: in_data  input  128  ciphertext block, state_t byte order.
REQ-007 SHALL have port: in_key  input  128  final (round NUM_ROUNDS) round key, roundKey_t order.
REQ-008 SHALL have port: out_valid  output  1  plaintext available.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts plaintext this cycle.
REQ-010 SHALL have port: out_data  output  128  recovered plaintext block.

Function
REQ-011 SHALL be iterative: one block in flight, one inverse round per clock, reusing the existing InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns logic.
REQ-012 SHALL implement states IDLE, ROUND, FINAL, DONE.
REQ-013 IDLE: in_ready=1. Accept when in_valid&&in_ready. On accept: state<=in_data^in_key, key<=in_key, round counter<=NUM_ROUNDS-1, go ROUND.
REQ-014 ROUND: each cycle derive round key k[r] from k[r+1] by inverse key expansion. Apply InvShiftRows, InvSubBytes, AddRoundKey(k[r]), then InvMixColumns. Decrement counter. When counter==1, go FINAL.
REQ-015 FINAL: derive k[0]. Apply InvShiftRows, InvSubBytes, AddRoundKey(k[0]) with no InvMixColumns. Register the result to out_data and go DONE.
REQ-016 Inverse key expansion, words w0..w3 of k[r] from v0..v3 of k[r+1]:
  - w3=v3^v2, w2=v2^v1, w1=v1^v0
  - w0=v0^SubWord(RotWord(w3))^Rcon[r+1]
  - Rcon[10..1] = 36,1B,80,40,20,10,08,04,02,01 (MSB byte, other bytes 0)
REQ-017 DONE: out_valid=1, out_data stable. Go IDLE on out_valid&&out_ready. in_ready=0 in DONE.
REQ-018 Latency: out_valid SHALL rise exactly NUM_ROUNDS rising edges after the accepting edge. Next accept SHALL be possible no earlier than the cycle after the output handshake.
REQ-019 in_ready SHALL be 0 in ROUND, FINAL and DONE. in_data/in_key changes outside the accept cycle SHALL have no effect.
REQ-020 out_valid SHALL remain asserted with unchanged out_data for any number of cycles while out_ready=0. out_ready while out_valid=0 SHALL be ignored.
REQ-021 in_valid asserted while busy SHALL be neither accepted nor lost-state-causing. The source holds it until in_ready.
REQ-022 All arithmetic is GF(2^8) / XOR; no width growth; no carries.

Reset
REQ-023 While reset=0 at a rising edge: state<=IDLE, out_valid<=0, out_data<=0, counter<=0, internal state/key registers<=0.
REQ-024 in_ready SHALL be 0 while reset=0, and 1 on the first cycle after reset deasserts.
REQ-025 Reset asserted in ROUND, FINAL or DONE SHALL abort the block silently, with no out_valid pulse afterward.

Verification
REQ-026 FIPS-197 C.1: in_data=69C4E0D86A7B0430D8CDB78070B4C55A, in_key=13111D7FE3944A17F307A78B4D2B30C5 -> out_data=00112233445566778899AABBCCDDEEFF, out_valid exactly 10 edges after accept.
REQ-027 FIPS-197 App. B: in_data=3925841D02DC09FBDC118597196A0B32, in_key=D014F9A8C9EE2589E13F0CC8B6630CA6 -> out_data=3243F6A8885A308D313198A2E0370734.
REQ-028 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data unchanged, in_ready=0 throughout; handshake on cycle 6 -> IDLE and in_ready=1 next cycle.
REQ-029 Busy input: change in_data/in_key and hold in_valid=1 during ROUND -> first result still matches REQ-026. The second pair is accepted only after the output handshake and decrypts correctly.
REQ-030 Reset mid-operation: reset=0 for 1 cycle at round counter 5 -> out_valid never rises for that block, outputs 0. The next REQ-027 vector then produces the correct result.
REQ-031 Back-to-back: the REQ-026 then REQ-027 vectors with out_ready tied to 1 -> two correct results, accepts spaced NUM_ROUNDS+2 cycles apart.
